// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register with valid/ready handshake and next-PC select decode.
// Define IF_ID_SKID_EN for 2-entry skid storage with registered in_ready; the default build holds 1 entry.
module if_id_pipe #(
  parameter int              DW     = 32,
  parameter int              AW     = 32,
  parameter logic [AW-1:0]   RST_PC = AW'(32'h0000_3000),
  parameter int              BR_EXT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [1:0]    pc_src,
  output logic [1:0]    count
);

  logic [1:0]    cnt;
  logic [DW-1:0] head_instr;
  logic [AW-1:0] head_pc;
  logic          push;
  logic          pop;
  logic [5:0]    op;
  logic [5:0]    funct;

  assign out_valid = (cnt != 2'd0);
  assign out_instr = head_instr;
  assign out_pc    = head_pc;
  assign count     = cnt;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && in_ready;

`ifdef IF_ID_SKID_EN
  logic [DW-1:0] tail_instr;
  logic [AW-1:0] tail_pc;

  // Ready depends only on the held count, so it never combinationally follows out_ready.
  assign in_ready = reset && (cnt != 2'd2);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      cnt        <= 2'd0;
      head_instr <= '0;
      head_pc    <= RST_PC;
      tail_instr <= '0;
      tail_pc    <= RST_PC;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            head_instr <= in_instr;
            head_pc    <= in_pc;
            cnt        <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_instr <= in_instr;
            head_pc    <= in_pc;
          end else if (push) begin
            tail_instr <= in_instr;
            tail_pc    <= in_pc;
            cnt        <= 2'd2;
          end else if (pop) begin
            head_instr <= '0;
            head_pc    <= RST_PC;
            cnt        <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= '0;
            tail_pc    <= RST_PC;
            cnt        <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end
`else
  assign in_ready = reset && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      cnt        <= 2'd0;
      head_instr <= '0;
      head_pc    <= RST_PC;
    end else if (push) begin
      head_instr <= in_instr;
      head_pc    <= in_pc;
      cnt        <= 2'd1;
    end else if (pop) begin
      head_instr <= '0;
      head_pc    <= RST_PC;
      cnt        <= 2'd0;
    end
  end
`endif

  assign op    = out_instr[31:26];
  assign funct = out_instr[5:0];

  always_comb begin
    pc_src = 2'd0;
    if (out_valid) begin
      case (op)
        6'b000100:            pc_src = 2'd1;
        6'b000010, 6'b000011: pc_src = 2'd2;
        6'b000000: begin
          if (funct == 6'b001000 || funct == 6'b001001) pc_src = 2'd3;
        end
        6'b000101, 6'b000110, 6'b000111, 6'b000001: begin
          if (BR_EXT != 0) pc_src = 2'd1;
        end
        default: pc_src = 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: two instances (BR_EXT=0/1) share stimulus; a queue model predicts
// acceptance, occupancy and head contents, and a negedge monitor compares.
module tb_if_id_pipe;

`ifdef IF_ID_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_instr0, out_pc0, out_instr1, out_pc1;
  logic [1:0]  pc_src0, count0, pc_src1, count1;

  if_id_pipe #(.DW(32), .AW(32), .RST_PC(RST_PC), .BR_EXT(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_instr(out_instr0), .out_pc(out_pc0),
    .pc_src(pc_src0), .count(count0)
  );

  if_id_pipe #(.DW(32), .AW(32), .RST_PC(RST_PC), .BR_EXT(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_instr(out_instr1), .out_pc(out_pc1),
    .pc_src(pc_src1), .count(count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   started = 1'b0;
  logic exp_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_pc_src(input logic [31:0] i, input bit ext);
    logic [5:0] op;
    logic [5:0] fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h04) return 2'd1;
    if (op == 6'h02 || op == 6'h03) return 2'd2;
    if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) return 2'd3;
    if (ext && (op == 6'h05 || op == 6'h06 || op == 6'h07 || op == 6'h01)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: r[31:26] = 6'h04;
      1: r[31:26] = 6'($urandom_range(2, 3));
      2: begin r[31:26] = 6'h00; r[5:0] = 6'($urandom_range(8, 9)); end
      3: r[31:26] = 6'($urandom_range(5, 7));
      4: r[31:26] = 6'h01;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor + reference model: check what the DUT presents, then advance the model
  // with this cycle's inputs (they take effect at the next rising edge).
  always @(negedge clk) begin
    if (started) begin
      if (!reset)              exp_rdy = 1'b0;
      else if (DEPTH == 2)     exp_rdy = (q.size() < 2);
      else                     exp_rdy = (q.size() == 0) || out_ready;
      chk("in_ready", 32'(in_ready0), 32'(exp_rdy));
      chk("count", 32'(count0), q.size());
      chk("out_valid", 32'(out_valid0), 32'(q.size() != 0));
      chk("out_valid_ext", 32'(out_valid1), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_instr", out_instr0, q[0].instr);
        chk("out_pc", out_pc0, q[0].pc);
        chk("pc_src", 32'(pc_src0), 32'(ref_pc_src(q[0].instr, 1'b0)));
        chk("pc_src_ext", 32'(pc_src1), 32'(ref_pc_src(q[0].instr, 1'b1)));
      end else begin
        chk("idle_instr", out_instr0, 32'h0);
        chk("idle_pc", out_pc0, RST_PC);
        chk("idle_pc_src", 32'(pc_src0), 32'h0);
        chk("idle_pc_src_ext", 32'(pc_src1), 32'h0);
      end
      if (!reset || flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back('{instr: in_instr, pc: in_pc});
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    reset   = 1'b1;
    idle(1);

    // beq, then jal/jr back to back, then bne on both BR_EXT builds
    step(1'b1, 32'h1000_0003, 32'h3000, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 32'h0C00_0C00, 32'h3004, 1'b1, 1'b0);
    step(1'b1, 32'h03E0_0008, 32'h3008, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 32'h1420_0004, 32'h300C, 1'b1, 1'b0);
    idle(2);

    // stalled offers A, B, C; C must wait for space
    step(1'b1, 32'hAAAA_0001, 32'h4000, 1'b0, 1'b0);
    step(1'b1, 32'h1000_0002, 32'h4004, 1'b0, 1'b0);
    step(1'b1, 32'h0800_0003, 32'h4008, 1'b0, 1'b0);
    step(1'b1, 32'h0800_0003, 32'h4008, 1'b1, 1'b0);
    step(1'b1, 32'h0800_0003, 32'h4008, 1'b0, 1'b0);
    idle(4);

    // flush while full with a concurrent offer
    step(1'b1, 32'h1000_0010, 32'h5000, 1'b0, 1'b0);
    step(1'b1, 32'h1000_0011, 32'h5004, 1'b0, 1'b0);
    step(1'b1, 32'h1000_0012, 32'h5008, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // reset mid-stall with storage full
    step(1'b1, 32'h0C00_0020, 32'h6000, 1'b0, 1'b0);
    step(1'b1, 32'h0C00_0021, 32'h6004, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 32'h0C00_0022, 32'h6008, 1'b1, 1'b1);
    reset = 1'b1;
    idle(2);

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 63) == 0) reset = 1'b0;
      else reset = 1'b1;
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    reset = 1'b1;
    idle(6);
    chk("drained_count", 32'(count0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
